// File: rtl/target_tracker_if.sv
// Capture-to-tracker bundle: per-pixel write strobe and address, the
// per-frame detection result, and the tracked target presented downstream.
// The capture side drives through master; the tracker uses slave.
interface target_tracker_if;
  logic        enable_write_memory;
  logic [19:0] pos_pxl;
  logic        achou_out;
  logic [19:0] detect_pos_pixel;
  logic [9:0]  target_x;
  logic [9:0]  target_y;
  logic        target_valid;
  logic        update;
  logic        overrun;

  modport master (
    output enable_write_memory, pos_pxl, achou_out, detect_pos_pixel,
    input  target_x, target_y, target_valid, update, overrun
  );

  modport slave (
    input  enable_write_memory, pos_pxl, achou_out, detect_pos_pixel,
    output target_x, target_y, target_valid, update, overrun
  );
endinterface

// File: rtl/target_tracker.sv
// Per-frame target tracker. On the first pixel write of a frame it samples
// the detection, splits the linear position into (x, y) with a 20-step
// restoring divider, and publishes the coordinate with a validity flag that
// drops after LOST_FRAMES consecutive misses.
// Optional macro TARGET_TRACKER_SMOOTH_EN enables a first-order IIR filter
// on the coordinate (weight 2^-SMOOTH_SHIFT); without it the raw coordinate
// is loaded. Latency is identical in both builds.
module target_tracker #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int LOST_FRAMES  = 4,
  parameter int SMOOTH_SHIFT = 2
) (
  input logic            pclk,
  input logic            reset,
  target_tracker_if.slave trk
);

  localparam logic [10:0] DIVISOR   = 11'(H_RES);
  localparam logic [19:0] POS_LIMIT = 20'(H_RES * V_RES);
  localparam logic [3:0]  LOST_CNT  = 4'(LOST_FRAMES);
  localparam logic [4:0]  LAST_STEP = 5'd19;

`ifdef TARGET_TRACKER_SMOOTH_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_FILT, S_MISS, S_OUT} state_t;

  state_t      state_reg, state_next;
  logic [19:0] dvd_reg, dvd_next;     // dividend shifts out, quotient shifts in
  logic [9:0]  rem_reg, rem_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [9:0]  x_reg, x_next;
  logic [9:0]  y_reg, y_next;
  logic [3:0]  miss_reg, miss_next;
  logic        valid_reg, valid_next;
  logic        update_reg, update_next;
  logic        overrun_reg, overrun_next;

  logic        frame_event;
  logic        hit;
  logic [10:0] rem_shift;
  logic        quo_bit;
  logic [9:0]  rem_sub;

  assign frame_event = trk.enable_write_memory && (trk.pos_pxl == 20'd0);
  assign hit         = trk.achou_out && (trk.detect_pos_pixel < POS_LIMIT);

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem_reg, dvd_reg[19]};
  assign quo_bit   = (rem_shift >= DIVISOR);
  assign rem_sub   = 10'(rem_shift - DIVISOR);

  // c + ((raw - c) >>> SMOOTH_SHIFT) with 12-bit signed arithmetic. The
  // floor of the shift keeps the result between c and raw, so it never
  // leaves the coordinate range.
  function automatic logic [9:0] iir_step(input logic [9:0] cur, input logic [9:0] raw);
    logic signed [11:0] diff;
    logic signed [11:0] step;
    logic signed [11:0] sum;
    diff = $signed({2'b00, raw}) - $signed({2'b00, cur});
    step = diff >>> SMOOTH_SHIFT;
    sum  = $signed({2'b00, cur}) + step;
    return sum[9:0];
  endfunction

  // State and datapath registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      dvd_reg     <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      miss_reg    <= '0;
      valid_reg   <= 1'b0;
      update_reg  <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dvd_reg     <= dvd_next;
      rem_reg     <= rem_next;
      cnt_reg     <= cnt_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      miss_reg    <= miss_next;
      valid_reg   <= valid_next;
      update_reg  <= update_next;
      overrun_reg <= overrun_next;
    end
  end

  // Next-state and datapath: sample on a frame event, divide, filter or
  // count a miss, then pulse update from the OUT state.
  always_comb begin
    state_next   = state_reg;
    dvd_next     = dvd_reg;
    rem_next     = rem_reg;
    cnt_next     = cnt_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    miss_next    = miss_reg;
    valid_next   = valid_reg;
    update_next  = 1'b0;
    overrun_next = overrun_reg | (frame_event && (state_reg != S_IDLE));

    case (state_reg)
      S_IDLE: begin
        if (frame_event) begin
          if (hit) begin
            dvd_next   = trk.detect_pos_pixel;
            rem_next   = '0;
            cnt_next   = '0;
            state_next = S_DIV;
          end else begin
            state_next = S_MISS;
          end
        end
      end
      S_DIV: begin
        rem_next = quo_bit ? rem_sub : rem_shift[9:0];
        dvd_next = {dvd_reg[18:0], quo_bit};
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == LAST_STEP) state_next = S_FILT;
      end
      S_FILT: begin
        // Remainder is the column, quotient (low bits) is the row.
        if (FILT_EN && valid_reg) begin
          x_next = iir_step(x_reg, rem_reg);
          y_next = iir_step(y_reg, dvd_reg[9:0]);
        end else begin
          x_next = rem_reg;
          y_next = dvd_reg[9:0];
        end
        miss_next   = '0;
        valid_next  = 1'b1;
        update_next = 1'b1;
        state_next  = S_OUT;
      end
      S_MISS: begin
        if (miss_reg < LOST_CNT) miss_next = miss_reg + 4'd1;
        if (miss_next >= LOST_CNT) valid_next = 1'b0;
        update_next = 1'b1;
        state_next  = S_OUT;
      end
      S_OUT: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign trk.target_x     = x_reg;
  assign trk.target_y     = y_reg;
  assign trk.target_valid = valid_reg;
  assign trk.update       = update_reg;
  assign trk.overrun      = overrun_reg;

endmodule

// File: tb/tb_target_tracker.sv
// Scoreboard bench for target_tracker: each frame event pushes the expected
// coordinate, validity and latency; the monitor pops and compares on update.
module tb_target_tracker;

  localparam int H       = 640;
  localparam int V       = 480;
  localparam int LOST    = 4;
  localparam int SHIFT   = 2;
`ifdef TARGET_TRACKER_SMOOTH_EN
  localparam bit SMOOTH  = 1'b1;
`else
  localparam bit SMOOTH  = 1'b0;
`endif

  logic pclk = 1'b0;
  logic reset = 1'b1;
  always #5 pclk = ~pclk;

  target_tracker_if trk ();

  target_tracker #(
    .H_RES(H), .V_RES(V), .LOST_FRAMES(LOST), .SMOOTH_SHIFT(SHIFT)
  ) dut (
    .pclk (pclk),
    .reset(reset),
    .trk  (trk)
  );

  typedef struct {
    int x;
    int y;
    int valid;
    int fe_cyc;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_upd = 0;
  logic prev_upd = 1'b0;

  // Reference model state
  int m_x = 0, m_y = 0, m_valid = 0, m_miss = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every update pulse must match the head of the scoreboard.
  always @(negedge pclk) begin
    if (trk.update === 1'b1) begin
      check("update_gap", int'(prev_upd), 0);
      if (sb_q.size() == 0) begin
        check("spurious_update", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_upd++;
        check("target_x", int'(trk.target_x), e.x);
        check("target_y", int'(trk.target_y), e.y);
        check("target_valid", int'(trk.target_valid), e.valid);
        check("latency", cyc - e.fe_cyc, e.lat);
        $display("update %0d: x=%0d y=%0d valid=%0d latency=%0d", n_upd,
                 trk.target_x, trk.target_y, trk.target_valid, cyc - e.fe_cyc);
      end
    end
    prev_upd = trk.update;
  end

  // Drive a frame event at cycle 0, a non-frame write at cycle 1, then idle.
  task automatic drive_fe(input logic ach, input logic [19:0] pos);
    exp_t e;
    int rx, ry;
    @(negedge pclk);
    trk.enable_write_memory = 1'b1;
    trk.pos_pxl             = 20'd0;
    trk.achou_out           = ach;
    trk.detect_pos_pixel    = pos;
    if (ach && int'(pos) < H * V) begin
      rx = int'(pos) % H;
      ry = int'(pos) / H;
      if (SMOOTH && m_valid != 0) begin
        m_x = m_x + ((rx - m_x) >>> SHIFT);
        m_y = m_y + ((ry - m_y) >>> SHIFT);
      end else begin
        m_x = rx;
        m_y = ry;
      end
      m_valid = 1;
      m_miss  = 0;
      e.lat   = 22;
    end else begin
      if (m_miss < LOST) m_miss++;
      if (m_miss >= LOST) m_valid = 0;
      e.lat = 2;
    end
    e.x = m_x; e.y = m_y; e.valid = m_valid; e.fe_cyc = cyc;
    sb_q.push_back(e);
    @(negedge pclk);
    trk.pos_pxl = 20'd1;
    @(negedge pclk);
    trk.enable_write_memory = 1'b0;
    trk.pos_pxl             = 20'd0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80 && sb_q.size() != 0; i++) @(negedge pclk);
    check("drain_timeout", sb_q.size(), 0);
    repeat (3) @(negedge pclk);
  endtask

  task automatic run_frame(input logic ach, input logic [19:0] pos);
    drive_fe(ach, pos);
    wait_drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, int'(trk.target_x), 0);
    check({tag, "_y"}, int'(trk.target_y), 0);
    check({tag, "_valid"}, int'(trk.target_valid), 0);
    check({tag, "_update"}, int'(trk.update), 0);
    check({tag, "_overrun"}, int'(trk.overrun), 0);
  endtask

  initial begin
    trk.enable_write_memory = 1'b0;
    trk.pos_pxl             = 20'd0;
    trk.achou_out           = 1'b0;
    trk.detect_pos_pixel    = 20'd0;

    // Reset, then a long idle with no frame events.
    reset = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    check_reset_outputs("reset");
    repeat (100) @(negedge pclk);
    check_reset_outputs("idle");

    // Single hit, then a stray non-frame write stream with detection high.
    run_frame(1'b1, 20'd64325);
    trk.achou_out = 1'b1;
    trk.enable_write_memory = 1'b1;
    for (int i = 0; i < 5; i++) begin
      trk.pos_pxl = 20'(100 + i);
      @(negedge pclk);
    end
    trk.enable_write_memory = 1'b0;
    trk.pos_pxl = 20'd0;
    repeat (30) @(negedge pclk);

    // Lost target: three misses, then an out-of-range position as the 4th.
    run_frame(1'b0, 20'd0);
    run_frame(1'b0, 20'd5);
    run_frame(1'b0, 20'd64325);
    run_frame(1'b1, 20'd307200);
    run_frame(1'b1, 20'd3210);            // (10,5) reloads raw
    check("overrun_clear", int'(trk.overrun), 0);

    // Lose again, then smoothing pair (400,200) -> (480,240).
    for (int i = 0; i < LOST; i++) run_frame(1'b0, 20'd0);
    run_frame(1'b1, 20'd128400);
    run_frame(1'b1, 20'd154080);
    run_frame(1'b1, 20'd307199);          // corner (639,479)
    run_frame(1'b1, 20'd0);               // pull back toward origin
    run_frame(1'b0, 20'd0);               // extra miss beyond saturation path

    // Overrun: a second frame event in cycle 10 of a division is dropped.
    drive_fe(1'b1, 20'd1000);
    repeat (8) @(negedge pclk);
    trk.enable_write_memory = 1'b1;
    trk.pos_pxl             = 20'd0;
    trk.achou_out           = 1'b1;
    trk.detect_pos_pixel    = 20'd5;
    @(negedge pclk);
    trk.enable_write_memory = 1'b0;
    wait_drain();
    check("overrun_set", int'(trk.overrun), 1);
    run_frame(1'b1, 20'd2000);
    check("overrun_sticky", int'(trk.overrun), 1);

    // Reset in cycle 12 of a division: no update, outputs back to reset.
    drive_fe(1'b1, 20'd50000);
    repeat (10) @(negedge pclk);
    sb_q.delete();
    m_x = 0; m_y = 0; m_valid = 0; m_miss = 0;
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
    repeat (30) @(negedge pclk);
    check_reset_outputs("mid_div_reset");
    run_frame(1'b1, 20'd64325);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
